// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode/funct constants, ALU op codes and immediate types
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction with sign extension
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I decode/issue stage: ALU op decode, operand select, forwarding
module alu_decode_stage #(
  parameter int              XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_PC_OPERAND = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] fwd_data,
  output logic [3:0]      op_val,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic            jump_instruction,
  output logic            signed_unsigned_n,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic            ex_illegal
);
  import riscv_pkg::*;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  logic [3:0]      op_val_q, op_val_d;
  logic [XLEN-1:0] operand_a_q, operand_a_d;
  logic [XLEN-1:0] operand_b_q, operand_b_d;
  logic            jump_q, jump_d;
  logic            signed_q, signed_d;
  logic            ex_valid_q, ex_valid_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_rd_we_q, ex_rd_we_d;
  logic            ex_illegal_q, ex_illegal_d;

  imm_type_e   imm_type;
  logic [31:0] imm;

  always_comb begin
    imm_type = IMM_I;
    case (opcode)
      OPC_STORE:          imm_type = IMM_S;
      OPC_BRANCH:         imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
      OPC_JAL:            imm_type = IMM_J;
      default:            imm_type = IMM_I;
    endcase
  end

  imm_gen u_imm_gen (
    .instr    (if_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // Back-to-back dependency: the execute-stage result is not yet in the register file.
  logic            fwd_rs1, fwd_rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, shamt;

  assign fwd_rs1 = ex_valid_q & ex_rd_we_q & (ex_rd_q == rs1_addr);
  assign fwd_rs2 = ex_valid_q & ex_rd_we_q & (ex_rd_q == rs2_addr);
  assign rs1_val = fwd_rs1 ? fwd_data : rs1_data;
  assign rs2_val = fwd_rs2 ? fwd_data : rs2_data;
  assign shamt   = {{(XLEN-5){1'b0}}, if_instr[24:20]};

  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_jump, dec_signed, dec_we, dec_illegal;

  always_comb begin
    dec_op      = ALU_NOP;
    dec_a       = rs1_val;
    dec_b       = rs2_val;
    dec_jump    = 1'b0;
    dec_signed  = 1'b0;
    dec_we      = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_we = 1'b1;
        if (!(funct7 == F7_BASE ||
              (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR))))
          dec_illegal = 1'b1;
        case (funct3)
          F3_ADD_SUB: dec_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:     dec_op = ALU_SLL;
          F3_SLT:     begin dec_op = ALU_SLT; dec_signed = 1'b1; end
          F3_SLTU:    dec_op = ALU_SLTU;
          F3_XOR:     dec_op = ALU_XOR;
          F3_SR: begin
            dec_op     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_signed = (funct7 == F7_ALT);
          end
          F3_OR:      dec_op = ALU_OR;
          default:    dec_op = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec_we = 1'b1;
        dec_b  = imm;
        case (funct3)
          F3_ADD_SUB: dec_op = ALU_ADD;
          F3_SLL: begin
            dec_op      = ALU_SLL;
            dec_b       = shamt;
            dec_illegal = (funct7 != F7_BASE);
          end
          F3_SLT:     begin dec_op = ALU_SLT; dec_signed = 1'b1; end
          F3_SLTU:    dec_op = ALU_SLTU;
          F3_XOR:     dec_op = ALU_XOR;
          F3_SR: begin
            dec_op      = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_signed  = (funct7 == F7_ALT);
            dec_b       = shamt;
            dec_illegal = !(funct7 == F7_BASE || funct7 == F7_ALT);
          end
          F3_OR:      dec_op = ALU_OR;
          default:    dec_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_op = ALU_ADD;
        dec_a  = '0;
        dec_b  = imm;
        dec_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op = ALU_ADD;
        dec_a  = if_pc;
        dec_b  = imm;
        dec_we = 1'b1;
      end
      OPC_JAL: begin
        dec_op   = ALU_ADD;
        dec_a    = if_pc;
        dec_b    = imm;
        dec_jump = 1'b1;
        dec_we   = 1'b1;
      end
      OPC_JALR: begin
        dec_op      = ALU_ADD;
        dec_b       = imm;
        dec_jump    = 1'b1;
        dec_we      = 1'b1;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        dec_op      = ALU_ADD;
        dec_b       = imm;
        dec_we      = 1'b1;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_op      = ALU_ADD;
        dec_b       = imm;
        dec_illegal = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec_op      = ALU_SUB;
        dec_signed  = !(funct3 == F3_BLTU || funct3 == F3_BGEU);
        dec_illegal = !(funct3 == F3_BEQ || funct3 == F3_BNE || funct3 == F3_BLT ||
                        funct3 == F3_BGE || funct3 == F3_BLTU || funct3 == F3_BGEU);
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op     = ALU_NOP;
      dec_we     = 1'b0;
      dec_jump   = 1'b0;
      dec_signed = 1'b0;
    end
    if (rd == 5'd0)
      dec_we = 1'b0;
  end

  // Priority below reset: flush squashes even when halted, otherwise halt freezes.
  always_comb begin
    op_val_d     = op_val_q;
    operand_a_d  = operand_a_q;
    operand_b_d  = operand_b_q;
    jump_d       = jump_q;
    signed_d     = signed_q;
    ex_valid_d   = ex_valid_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_we_d   = ex_rd_we_q;
    ex_illegal_d = ex_illegal_q;
    if (flush || (!halt && !if_valid)) begin
      op_val_d     = ALU_NOP;
      operand_a_d  = RESET_PC_OPERAND;
      operand_b_d  = RESET_PC_OPERAND;
      jump_d       = 1'b0;
      signed_d     = 1'b0;
      ex_valid_d   = 1'b0;
      ex_rd_d      = 5'd0;
      ex_rd_we_d   = 1'b0;
      ex_illegal_d = 1'b0;
    end else if (!halt) begin
      op_val_d     = dec_op;
      operand_a_d  = dec_a;
      operand_b_d  = dec_b;
      jump_d       = dec_jump;
      signed_d     = dec_signed;
      ex_valid_d   = 1'b1;
      ex_rd_d      = rd;
      ex_rd_we_d   = dec_we;
      ex_illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_val_q     <= ALU_NOP;
      operand_a_q  <= RESET_PC_OPERAND;
      operand_b_q  <= RESET_PC_OPERAND;
      jump_q       <= 1'b0;
      signed_q     <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= 5'd0;
      ex_rd_we_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      op_val_q     <= op_val_d;
      operand_a_q  <= operand_a_d;
      operand_b_q  <= operand_b_d;
      jump_q       <= jump_d;
      signed_q     <= signed_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_we_q   <= ex_rd_we_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign op_val            = op_val_q;
  assign operand_a         = operand_a_q;
  assign operand_b         = operand_b_q;
  assign jump_instruction  = jump_q;
  assign signed_unsigned_n = signed_q;
  assign ex_valid          = ex_valid_q;
  assign ex_rd             = ex_rd_q;
  assign ex_rd_we          = ex_rd_we_q;
  assign ex_illegal        = ex_illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - vector table and scoreboard bench for alu_decode_stage
module tb_alu_decode_stage;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, fwd;
    logic        valid, halt, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        jump, sgn, exv, we, ill, chk_ops;
    logic [4:0]  rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0, flush = 1'b0, if_valid = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0, rs1_data = '0, rs2_data = '0, fwd_data = '0;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd;
  logic [3:0]  op_val;
  logic [31:0] operand_a, operand_b;
  logic        jump_instruction, signed_unsigned_n, ex_valid, ex_rd_we, ex_illegal;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32), .RESET_PC_OPERAND(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_data(fwd_data),
    .op_val(op_val), .operand_a(operand_a), .operand_b(operand_b),
    .jump_instruction(jump_instruction), .signed_unsigned_n(signed_unsigned_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  vec_t tbl[20];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s #%0d: got 0x%08h want 0x%08h", nm, idx, act, want);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, pc, r1, r2, fw,
                              input logic [3:0] op, input logic [31:0] a, b,
                              input logic jump, sgn, input logic [4:0] rd,
                              input logic we, ill, chk_ops);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = r1; v.rs2 = r2; v.fwd = fw;
    v.valid = 1'b1; v.halt = 1'b0; v.flush = 1'b0;
    v.op = op; v.a = a; v.b = b; v.jump = jump; v.sgn = sgn;
    v.exv = 1'b1; v.rd = rd; v.we = we; v.ill = ill; v.chk_ops = chk_ops;
    return v;
  endfunction

  function automatic vec_t bubble(input vec_t src);
    vec_t v = src;
    v.op = 4'h0; v.jump = 1'b0; v.exv = 1'b0; v.we = 1'b0; v.ill = 1'b0; v.chk_ops = 1'b0;
    return v;
  endfunction

  task automatic compare_out(input vec_t e, input int idx);
    chk("op_val", idx, {28'b0, op_val}, {28'b0, e.op});
    chk("ex_valid", idx, {31'b0, ex_valid}, {31'b0, e.exv});
    chk("ex_rd_we", idx, {31'b0, ex_rd_we}, {31'b0, e.we});
    chk("ex_illegal", idx, {31'b0, ex_illegal}, {31'b0, e.ill});
    chk("jump", idx, {31'b0, jump_instruction}, {31'b0, e.jump});
    if (e.chk_ops) begin
      chk("operand_a", idx, operand_a, e.a);
      chk("operand_b", idx, operand_b, e.b);
      chk("signed", idx, {31'b0, signed_unsigned_n}, {31'b0, e.sgn});
    end
    if (e.we) chk("ex_rd", idx, {27'b0, ex_rd}, {27'b0, e.rd});
  endtask

  task automatic drive(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    if_instr = v.instr; if_pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2; fwd_data = v.fwd;
    if_valid = v.valid; halt = v.halt; flush = v.flush;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare_out(e, idx);
  endtask

  task automatic chk_reset_state(input int idx);
    chk("rst_op_val", idx, {28'b0, op_val}, 32'h0);
    chk("rst_operand_a", idx, operand_a, 32'h0);
    chk("rst_operand_b", idx, operand_b, 32'h0);
    chk("rst_flags", idx, {27'b0, jump_instruction, signed_unsigned_n, ex_valid, ex_rd_we, ex_illegal}, 32'h0);
    chk("rst_ex_rd", idx, {27'b0, ex_rd}, 32'h0);
  endtask

  initial begin
    vec_t addi, h;
    //            instr         pc       rs1          rs2    fwd          op    a            b            j  s  rd  we ill chk
    tbl[0]  = mk(32'h00500093, 32'h0,   32'h0,       32'h0, 32'h0,       4'h1, 32'h0,       32'h5,       0, 0, 1,  1, 0, 1);
    tbl[1]  = mk(32'h402081B3, 32'h4,   32'h99,      32'h2, 32'h5,       4'h2, 32'h5,       32'h2,       0, 0, 3,  1, 0, 1);
    tbl[2]  = mk(32'h40335293, 32'h8,   32'h80000000,32'h0, 32'hDEAD,    4'h9, 32'h80000000,32'h3,       0, 1, 5,  1, 0, 1);
    tbl[3]  = mk(32'hFE335293, 32'hC,   32'h1,       32'h0, 32'hDEAD,    4'h0, 32'h0,       32'h0,       0, 0, 5,  0, 1, 0);
    tbl[4]  = mk(32'h008000EF, 32'h100, 32'h0,       32'h0, 32'h0,       4'h1, 32'h100,     32'h8,       1, 0, 1,  1, 0, 1);
    tbl[5]  = mk(32'h123453B7, 32'h104, 32'h77,      32'h0, 32'h55,      4'h1, 32'h0,       32'h12345000,0, 0, 7,  1, 0, 1);
    tbl[6]  = mk(32'h00738233, 32'h108, 32'h1,       32'h2, 32'h12345000,4'h1, 32'h12345000,32'h12345000,0, 0, 4,  1, 0, 1);
    tbl[7]  = mk(32'hFFF23413, 32'h10C, 32'h9,       32'h0, 32'h77,      4'hB, 32'h77,      32'hFFFFFFFF,0, 0, 8,  1, 0, 1);
    tbl[8]  = mk(32'h0020E063, 32'h110, 32'd10,      32'd20,32'h55,      4'h2, 32'd10,      32'd20,      0, 0, 0,  0, 0, 1);
    tbl[9]  = mk(32'h0041D063, 32'h114, 32'd3,       32'd4, 32'h55,      4'h2, 32'd3,       32'd4,       0, 1, 0,  0, 0, 1);
    tbl[10] = mk(32'h00100013, 32'h118, 32'h0,       32'h0, 32'h55,      4'h1, 32'h0,       32'h1,       0, 0, 0,  0, 0, 1);
    tbl[11] = mk(32'hFFC5A503, 32'h11C, 32'h1000,    32'h0, 32'h55,      4'h1, 32'h1000,    32'hFFFFFFFC,0, 0, 10, 1, 0, 1);
    tbl[12] = mk(32'h00C6A423, 32'h120, 32'h2000,    32'h9, 32'h55,      4'h1, 32'h2000,    32'h8,       0, 0, 0,  0, 0, 1);
    tbl[13] = mk(32'h00C280E7, 32'h124, 32'h300,     32'h0, 32'h55,      4'h1, 32'h300,     32'hC,       1, 0, 1,  1, 0, 1);
    tbl[14] = mk(32'h00001117, 32'h200, 32'h3,       32'h0, 32'h55,      4'h1, 32'h200,     32'h1000,    0, 0, 2,  1, 0, 1);
    tbl[15] = mk(32'h00315333, 32'h204, 32'h1,       32'h4, 32'hABC,     4'h8, 32'hABC,     32'h4,       0, 0, 6,  1, 0, 1);
    tbl[16] = mk(32'h0000007F, 32'h208, 32'h0,       32'h0, 32'h0,       4'h0, 32'h0,       32'h0,       0, 0, 0,  0, 1, 0);
    tbl[17] = mk(32'h40004033, 32'h20C, 32'h0,       32'h0, 32'h0,       4'h0, 32'h0,       32'h0,       0, 0, 0,  0, 1, 0);
    tbl[18] = mk(32'h001090B3, 32'h210, 32'h7,       32'h3, 32'h55,      4'h7, 32'h7,       32'h3,       0, 0, 1,  1, 0, 1);
    tbl[19] = mk(32'h40109093, 32'h214, 32'h7,       32'h0, 32'h55,      4'h0, 32'h0,       32'h0,       0, 0, 1,  0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state(0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) drive(tbl[i], i);

    // Halt holds the loaded ADDI while fetch presents other instructions.
    addi = tbl[0];
    drive(addi, 100);
    for (int i = 0; i < 3; i++) begin
      h = addi;
      h.instr = 32'h402081B3; h.rs1 = 32'h99; h.fwd = 32'h5; h.halt = 1'b1;
      drive(h, 101 + i);
    end
    h = bubble(addi);
    h.halt = 1'b1; h.flush = 1'b1;
    drive(h, 104);

    drive(tbl[4], 105);
    h = bubble(tbl[5]); h.flush = 1'b1;
    drive(h, 106);
    drive(tbl[5], 107);
    h = bubble(tbl[0]); h.valid = 1'b0;
    drive(h, 108);

    drive(addi, 109);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state(110);
    @(negedge clk);
    rst = 1'b0;
    drive(addi, 111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
